// File: rtl/cpu_ex_pkg.sv
// Shared definitions for the EX->WB stage: condition codes, flag bit positions, write entry.
package cpu_ex_pkg;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_RW = 4;

    // Register-file write entry at the default data/index widths.
    typedef struct packed {
        logic [WB_RW-1:0] dst;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cpu_cond_eval.sv
// Combinational condition-code evaluator against {Z,C,V,N} flags.
module cpu_cond_eval
    import cpu_ex_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, v, n;

    always_comb begin
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        n = flags[FLAG_N];
        pass = 1'b0;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ex_wb.sv
// EX->WB stage: flag register, condition gating, squash counter and 2-entry write skid buffer.
// Optional forwarding lookup over buffered writes is enabled by defining CPU_EX_FWD_EN.
module cpu_ex_wb
    import cpu_ex_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned RW   = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [DW-1:0]   ex_rd,
    input  logic [3:0]      ex_flags,
    input  logic [RW-1:0]   ex_dst,
    input  logic            ex_we,
    input  logic            ex_setf,
    input  logic [3:0]      ex_cond,
    output logic [3:0]      flag_q,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RW-1:0]   wb_dst,
    output logic [DW-1:0]   wb_data,
    output logic [CNTW-1:0] squash_cnt
`ifdef CPU_EX_FWD_EN
   ,input  logic [RW-1:0]   fwd_idx,
    output logic            fwd_hit,
    output logic [DW-1:0]   fwd_data
`endif
);

    typedef struct packed {
        logic [RW-1:0] dst;
        logic [DW-1:0] data;
    } entry_t;

    entry_t out_q, skid_q, new_e;
    logic   out_valid, skid_valid;
    logic   pass, accept, enq, pop;

    cpu_cond_eval u_cond (
        .cond  (ex_cond),
        .flags (flag_q),
        .pass  (pass)
    );

    assign ex_ready = !skid_valid;
    assign accept   = ex_valid && ex_ready;
    assign enq      = accept && pass && ex_we;
    assign pop      = out_valid && wb_ready;
    assign new_e    = '{dst: ex_dst, data: ex_rd};

    assign wb_valid = out_valid;
    assign wb_dst   = out_q.dst;
    assign wb_data  = out_q.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q     <= '0;
            squash_cnt <= '0;
        end else if (accept) begin
            if (pass && ex_setf)
                flag_q <= ex_flags;
            if (!pass && squash_cnt != '1)
                squash_cnt <= squash_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    // A pop with skid occupied cannot coincide with an enqueue: ex_ready is low then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                skid_valid <= 1'b0;
            end else if (enq) begin
                out_q <= new_e;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (enq) begin
            if (!out_valid) begin
                out_q     <= new_e;
                out_valid <= 1'b1;
            end else begin
                skid_q     <= new_e;
                skid_valid <= 1'b1;
            end
        end
    end

`ifdef CPU_EX_FWD_EN
    // The skid entry is younger, so it wins when both entries match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (skid_valid && skid_q.dst == fwd_idx) begin
            fwd_hit  = 1'b1;
            fwd_data = skid_q.data;
        end else if (out_valid && out_q.dst == fwd_idx) begin
            fwd_hit  = 1'b1;
            fwd_data = out_q.data;
        end
    end
`endif

endmodule
